// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: RV32I load/store funct3 values,
// FSM states and the access-size / alignment helpers used by decode and extraction.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_t;

    // Any funct3 that is not a byte or halfword encoding behaves as a word access.
    function automatic access_size_t access_size(input logic [2:0] funct3);
        access_size_t size;
        case (funct3)
            F3_B, F3_BU: size = SZ_BYTE;
            F3_H, F3_HU: size = SZ_HALF;
            default:     size = SZ_WORD;
        endcase
        return size;
    endfunction

    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] lane);
        logic ok;
        case (access_size(funct3))
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lane[0];
            default: ok = (lane == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_extract.sv
// Picks the addressed byte or halfword out of a returned RAM word and
// sign- or zero-extends it according to the load funct3.
module load_extract
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the byte and halfword addressed by the lane
    always_comb begin
        byte_s = 8'd0;
        half_s = 16'd0;
        case (lane)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        if (lane[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extend the selected field to 32 bits
    always_comb begin
        value = rdata;
        case (funct3)
            F3_B:    value = {{24{byte_s[7]}}, byte_s};
            F3_BU:   value = {24'd0, byte_s};
            F3_H:    value = {{16{half_s[15]}}, half_s};
            F3_HU:   value = {16'd0, half_s};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one request/acknowledge RAM transaction per
// aligned load/store, stalls the pipeline until it completes, and faults misaligned accesses.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_alu_rd_result,
    input  logic [31:0]       in_rs2_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       ram_data,
    output logic              stall,
    output logic              misaligned_fault
);

    mem_state_t  state_r;
    mem_state_t  state_next_s;

    logic        access_s;
    logic        aligned_s;
    logic        issue_s;
    logic        misaligned_s;
    logic        ack_s;
    logic [31:0] wdata_s;
    logic [3:0]  wstrb_s;
    logic [31:0] load_value_s;

    logic [1:0]  lane_r;
    logic [2:0]  funct3_r;
    logic        is_load_r;

    // Classify the instruction sitting in EX/MEM
    always_comb begin
        access_s     = in_valid & (in_mem_read | in_mem_write);
        aligned_s    = is_aligned(in_funct3, in_alu_rd_result[1:0]);
        issue_s      = (state_r == IDLE) & access_s & aligned_s;
        misaligned_s = (state_r == IDLE) & access_s & ~aligned_s;
        ack_s        = (state_r == BUSY) & mem_ack;
    end

    // Replicate store data across lanes and build the byte strobes
    always_comb begin
        wdata_s = in_rs2_data;
        wstrb_s = 4'b1111;
        case (access_size(in_funct3))
            SZ_BYTE: begin
                wdata_s = {4{in_rs2_data[7:0]}};
                wstrb_s = 4'b0001 << in_alu_rd_result[1:0];
            end
            SZ_HALF: begin
                wdata_s = {2{in_rs2_data[15:0]}};
                if (in_alu_rd_result[1]) begin
                    wstrb_s = 4'b1100;
                end else begin
                    wstrb_s = 4'b0011;
                end
            end
            default: begin
                wdata_s = in_rs2_data;
                wstrb_s = 4'b1111;
            end
        endcase
    end

    load_extract u_load_extract (
        .rdata  (mem_rdata),
        .lane   (lane_r),
        .funct3 (funct3_r),
        .value  (load_value_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; DONE always returns to IDLE so the held instruction is not re-issued
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (issue_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output: hold the pipeline from issue until the acknowledge has been taken
    always_comb begin
        if (issue_s || (state_r == BUSY)) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    // Request, write-data and load-result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= {ADDR_W{1'b0}};
            mem_wdata        <= 32'd0;
            mem_wstrb        <= 4'd0;
            ram_data         <= 32'd0;
            misaligned_fault <= 1'b0;
            lane_r           <= 2'd0;
            funct3_r         <= 3'd0;
            is_load_r        <= 1'b0;
        end else begin
            misaligned_fault <= misaligned_s;
            if (issue_s) begin
                mem_req   <= 1'b1;
                mem_we    <= in_mem_write;
                mem_addr  <= {in_alu_rd_result[ADDR_W-1:2], 2'b00};
                mem_wdata <= wdata_s;
                mem_wstrb <= in_mem_write ? wstrb_s : 4'd0;
                lane_r    <= in_alu_rd_result[1:0];
                funct3_r  <= in_funct3;
                is_load_r <= in_mem_read;
            end else if (ack_s) begin
                mem_req <= 1'b0;
                if (is_load_r) begin
                    ram_data <= load_value_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage: a byte-addressed reference memory
// predicts every RAM request, load result, stall length and misalignment fault.
module tb_mem_access_stage;
    import mem_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_mem_read, in_mem_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_rd_result, in_rs2_data;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, ram_data;
    logic [3:0]  mem_wstrb;
    logic        stall, misaligned_fault;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          wait_next = 0;
    logic        resp_en = 1'b1;
    logic        stray_ack = 1'b0;

    req_t        exp_req_q[$];
    logic [31:0] exp_done_q[$];
    int          exp_fault_q[$];
    logic [7:0]  ref_mem[1024];
    logic [31:0] ref_ram_data = 32'd0;
    logic [31:0] ram[256];
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wstrb;
    logic        last_we;

    mem_access_stage #(.ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_funct3(in_funct3), .in_alu_rd_result(in_alu_rd_result),
        .in_rs2_data(in_rs2_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ram_data(ram_data), .stall(stall), .misaligned_fault(misaligned_fault)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E37_79B9) ^ 32'hA5C3_0F1E;
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h, nothing was expected", name, act);
    endtask

    // Memory model: acknowledges after wait_next wait cycles and applies strobed writes
    initial begin
        for (int w = 0; w < 256; w++) ram[w] = init_word(w);
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            int wcnt;
            @(posedge clk);
            #1;
            if (!resp_en || !reset_n) begin
                wcnt = 0;
                mem_ack = stray_ack;
                if (stray_ack) mem_rdata = $urandom;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (wcnt >= wait_next) begin
                    mem_ack = 1'b1;
                    mem_rdata = ram[mem_addr[9:2]];
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) ram[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Monitor: checks requests every cycle, load results at completion, and fault pulses
    initial begin
        req_t e;
        logic prev_stall;
        logic fault_exp;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (mem_req) begin
                    if (exp_req_q.size() == 0) begin
                        fail_now("req_unexpected", mem_addr);
                    end else begin
                        e = exp_req_q[0];
                        check("req_we", 32'(mem_we), 32'(e.we));
                        check("req_addr", mem_addr, e.addr);
                        check("req_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
                        if (e.we) check("req_wdata", mem_wdata, e.wdata);
                        if (mem_ack) begin
                            last_addr = mem_addr;
                            last_wdata = mem_wdata;
                            last_wstrb = mem_wstrb;
                            last_we = mem_we;
                            void'(exp_req_q.pop_front());
                        end
                    end
                end
                if (prev_stall && !stall) begin
                    if (exp_done_q.size() == 0) fail_now("done_unexpected", ram_data);
                    else check("ram_data", ram_data, exp_done_q.pop_front());
                end
                prev_stall = stall;
                fault_exp = (exp_fault_q.size() > 0) && (exp_fault_q[0] == cyc);
                check("fault_pulse", 32'(misaligned_fault), 32'(fault_exp));
                if (fault_exp) void'(exp_fault_q.pop_front());
            end
        end
    end

    // Present one instruction, predict its outcome and hold it until the stage lets it go
    task automatic issue(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rs2, input int waits);
        int          n;
        int          cycles;
        logic        acc, ok;
        logic [31:0] val, mask;
        req_t        r;
        n   = nbytes(f3);
        acc = v & (rd | wr);
        ok  = (n == 1) || (n == 2 && !a[0]) || (n == 4 && a[1:0] == 2'b00);
        wait_next        = waits;
        in_valid         = v;
        in_mem_read      = rd;
        in_mem_write     = wr;
        in_funct3        = f3;
        in_alu_rd_result = a;
        in_rs2_data      = rs2;
        if (acc && ok) begin
            r.we = wr;
            r.addr = a & 32'hFFFF_FFFC;
            r.wdata = 32'd0;
            r.wstrb = 4'd0;
            if (wr) begin
                r.wstrb = 4'((32'd1 << n) - 32'd1) << a[1:0];
                case (n)
                    1:       r.wdata = {24'd0, rs2[7:0]} * 32'h0101_0101;
                    2:       r.wdata = {16'd0, rs2[15:0]} * 32'h0001_0001;
                    default: r.wdata = rs2;
                endcase
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'(rs2 >> (8 * i));
            end else begin
                val = 32'd0;
                for (int i = 0; i < n; i++) val = val | ({24'd0, ref_mem[int'(a) + i]} << (8 * i));
                if ((f3 == F3_B || f3 == F3_H) && val[8*n-1]) begin
                    mask = (32'd1 << (8 * n)) - 32'd1;
                    val = val | ~mask;
                end
                ref_ram_data = val;
            end
            exp_req_q.push_back(r);
            exp_done_q.push_back(ref_ram_data);
        end
        cycles = 0;
        @(negedge clk);
        while (stall === 1'b1 && cycles < 60) begin
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 60) fail_now("stall_timeout", 32'(cycles));
        if (acc && ok) check("stall_cycles", 32'(cycles), 32'(2 + waits));
        else check("no_stall", 32'(cycles), 32'd0);
        if (acc && !ok) exp_fault_q.push_back(cyc + 1);
        if (!acc) check("ram_hold", ram_data, ref_ram_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          kind;
        logic [2:0]  f3;
        logic [31:0] a;
        req_t        r;
        reset_n = 1'b0;
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_funct3 = 3'd0; in_alu_rd_result = 32'd0; in_rs2_data = 32'd0;
        for (int w = 0; w < 256; w++)
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = 8'(init_word(w) >> (8 * b));
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_ram_data", ram_data, 32'd0);
        check("rst_fault", 32'(misaligned_fault), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        issue(1'b1, 1'b0, 1'b1, F3_W, 32'h100, 32'h80FF_1234, 0);
        issue(1'b1, 1'b1, 1'b0, F3_B, 32'h103, 32'd0, 0);
        check("lb_sext", ram_data, 32'hFFFF_FF80);
        check("lb_addr", last_addr, 32'h100);
        issue(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0FFF, 32'h1234, 0);
        check("alu_after_load", ram_data, 32'hFFFF_FF80);
        issue(1'b1, 1'b0, 1'b1, F3_H, 32'h202, 32'hDEAD_BEEF, 0);
        check("sh_addr", last_addr, 32'h200);
        check("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        check("sh_wstrb", 32'(last_wstrb), 32'h0000_000C);
        check("sh_we", 32'(last_we), 32'd1);
        check("sh_ram_keep", ram_data, 32'hFFFF_FF80);
        issue(1'b1, 1'b0, 1'b1, F3_W, 32'h0, 32'h8001_0000, 1);
        issue(1'b1, 1'b1, 1'b0, F3_HU, 32'h2, 32'd0, 3);
        check("lhu_wait", ram_data, 32'h0000_8001);
        issue(1'b1, 1'b1, 1'b0, F3_W, 32'h6, 32'd0, 0);
        check("lw_misaligned_fault", 32'(misaligned_fault), 32'd1);
        check("lw_misaligned_noreq", 32'(mem_req), 32'd0);
        issue(1'b1, 1'b0, 1'b1, F3_H, 32'h11, 32'h5555_AAAA, 0);

        for (int k = 0; k < 200; k++) begin
            kind = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 1023));
            if (kind == 0) begin
                issue(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), a, $urandom, 0);
            end else if (kind == 1) begin
                issue(1'b0, 1'b1, 1'b0, F3_W, a, $urandom, 0);
            end else if (kind < 6) begin
                f3 = 3'($urandom_range(0, 7));
                issue(1'b1, 1'b1, 1'b0, f3, a, $urandom, $urandom_range(0, 3));
            end else begin
                f3 = 3'($urandom_range(0, 2));
                issue(1'b1, 1'b0, 1'b1, f3, a, $urandom, $urandom_range(0, 3));
            end
        end

        resp_en = 1'b0;
        r.we = 1'b0; r.addr = 32'h40; r.wdata = 32'd0; r.wstrb = 4'd0;
        exp_req_q.push_back(r);
        in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0;
        in_funct3 = F3_W; in_alu_rd_result = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_req", 32'(mem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        in_valid = 1'b0; in_mem_read = 1'b0;
        #1;
        check("rst_async_req", 32'(mem_req), 32'd0);
        exp_req_q.delete();
        exp_done_q.delete();
        ref_ram_data = 32'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        stray_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stray_ack = 1'b0;
        check("stray_ack_req", 32'(mem_req), 32'd0);
        check("stray_ack_ram", ram_data, 32'd0);
        check("stray_ack_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        resp_en = 1'b1;
        @(posedge clk); #1;
        issue(1'b1, 1'b1, 1'b0, F3_W, 32'h100, 32'd0, 2);
        issue(1'b1, 1'b1, 1'b0, F3_BU, 32'h101, 32'd0, 0);

        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        check("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
        check("fault_queue_drained", 32'(exp_fault_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage between the EX/MEM and MEM/WB pipeline registers. Takes the effective address, store data and load/store control from EX/MEM, runs a request/acknowledge transaction with the data RAM, and drives the formatted load result (`ram_data`) plus a `stall` that holds the pipeline until the access completes. Loads are sign- or zero-extended per RV32I `funct3`. Stores use byte-lane strobes. Misaligned accesses are rejected without touching memory.

## Interface
- `ADDR_W`, 32, width of `mem_addr`; low `ADDR_W` bits of the effective address
- `clk` input 1: clock, rising edge
- `reset_n` input 1: asynchronous, active-low reset
- `in_valid` input 1: the EX/MEM slot holds a live instruction
- `in_mem_read` input 1: instruction is a load
- `in_mem_write` input 1: instruction is a store; never set together with `in_mem_read`
- `in_funct3` input 3: access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
- `in_alu_rd_result` input 32: effective byte address
- `in_rs2_data` input 32: store data
- `mem_req` output 1: registered request, held until `mem_ack`
- `mem_we` output 1: 1 = write, 0 = read
- `mem_addr` output `ADDR_W`: word-aligned address, bits [1:0] = 0
- `mem_wdata` output 32: lane-replicated store data
- `mem_wstrb` output 4: byte-lane write strobes; 0 on reads
- `mem_ack` input 1: memory completes the current request this cycle
- `mem_rdata` input 32: read word, valid when `mem_ack` is high
- `ram_data` output 32: registered, extended load result for the MEM/WB register
- `stall` output 1: combinational; hold IF through EX/MEM and keep MEM/WB `write_enable` low
- `misaligned_fault` output 1: registered, one-cycle pulse

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE, memory access present:** a memory access is `in_valid & (in_mem_read | in_mem_write)`.
  - If it is aligned: latch `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb`, set `mem_req` = 1, and go to BUSY.
  - Aligned means halfword `addr[0]` = 0 and word `addr[1:0]` = 0.
- **IDLE, misaligned access:** no request, state stays IDLE, `misaligned_fault` pulses on the next cycle, `stall` = 0.
- **IDLE, no memory access:** pass-through, `stall` = 0, `ram_data` keeps its value.
- **BUSY:**
  - `mem_req` and all `mem_*` outputs stay stable until `mem_ack`.
  - On `mem_ack`: `mem_req` goes to 0; for a load, `ram_data` takes the extracted value; go to DONE.
- **DONE:** `stall` = 0 for exactly one cycle, so the instruction advances into MEM/WB. No re-issue. Go to IDLE.
- `stall` = (IDLE & aligned access) | BUSY.
- **Load extraction** (lane = `addr[1:0]`, latched at issue):
  - LB/LBU: byte at `mem_rdata[8*lane +: 8]`, sign- or zero-extended.
  - LH/LHU: half at `mem_rdata[16*addr[1] +: 16]`, sign- or zero-extended.
  - LW: the whole word.
- **Store formatting:**
  - SB: `wdata` = 4 copies of `rs2[7:0]`, `wstrb` = 1 << lane.
  - SH: `wdata` = 2 copies of `rs2[15:0]`, `wstrb` = 0011 or 1100.
  - SW: `wdata` = `rs2`, `wstrb` = 1111.
- An undefined `funct3` on an access is treated as a word access.
- `mem_ack` is ignored when `mem_req` = 0 (IDLE, DONE).
- Stores leave `ram_data` unchanged.

## Timing
- **Reset values (asynchronous):**
  - `state` = IDLE; `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `ram_data`, `misaligned_fault` all = 0.
  - `stall` = 0 unless an aligned access is presented.
- **Reset mid-transaction:** `mem_req` drops immediately. A late `mem_ack` after reset release is ignored.
- **Minimum access**, with the access presented at cycle 0:
  - cycle 1: `mem_req` = 1; `mem_ack` arrives the same cycle.
  - cycle 2: DONE, `ram_data` valid.
  - `stall` is high in cycles 0–1.
- **Memory wait states:** each wait cycle of `mem_ack` adds one BUSY cycle.
- **Back-to-back accesses:** the next access enters IDLE at cycle 3. Peak throughput is one access per 3 cycles.
- **Non-memory instructions:** zero added latency.

## Structure
- Package `mem_pkg`:
  - `funct3` constants: `F3_B`=000, `F3_H`=001, `F3_W`=010, `F3_BU`=100, `F3_HU`=101.
  - `mem_state_t` enum: IDLE, BUSY, DONE.
- Sub-module `load_extract`: combinational; takes `mem_rdata`, lane and `funct3`, returns the 32-bit extended value.

## Test plan
- **LB sign extension:** LB at `addr` 0x103, `mem_rdata` = 0x80FF_1234, `ack` 1 cycle after `req` → `mem_addr` = 0x100, `ram_data` = 0xFFFF_FF80, `stall` high for exactly 2 cycles.
- **SH upper half:** SH at 0x202, `rs2` = 0xDEAD_BEEF → `mem_addr` = 0x200, `wdata` = 0xBEEF_BEEF, `wstrb` = 1100, `mem_we` = 1; `ram_data` unchanged.
- **LHU with wait states:** LHU at 0x2, `mem_rdata` = 0x8001_0000, 3 wait states → `req`/`addr` stable for 4 cycles; `ram_data` = 0x0000_8001 in DONE.
- **Misaligned word load:** LW at 0x6 → `mem_req` never asserts, `misaligned_fault` = 1 for one cycle, `stall` = 0.
- **Reset mid-transaction:** `reset_n` low while BUSY → `mem_req` = 0 with no clock edge; a later stray `mem_ack` leaves `ram_data` = 0 and `state` = IDLE.
- **ALU instruction after a load:** ALU instruction presented in the cycle after DONE → `stall` = 0 and `ram_data` holds the prior load value.
